// File: rtl/egress_arbiter_if.sv
// Egress arbiter bus bundle.
// Groups the FIFO-side pop/data signals, the downstream valid/ready stream,
// the init pulse and the counter readback port.
//   master : arbiter side (drives pops, stream outputs, counter readback)
//   slave  : environment side (drives empty flags, FIFO data, readyIn, req/idx, init)
interface egress_if;
    logic        init;
    logic [3:0]  emptyP;
    logic [11:0] dataOutputP0;
    logic [11:0] dataOutputP1;
    logic [11:0] dataOutputP2;
    logic [11:0] dataOutputP3;
    logic        popOutP0;
    logic        popOutP1;
    logic        popOutP2;
    logic        popOutP3;
    logic [11:0] dataOut;
    logic [1:0]  portOut;
    logic        validOut;
    logic        readyIn;
    logic [1:0]  idx;
    logic        req;
    logic [4:0]  counterOut;
    logic        counterValid;

    modport master (
        input  init, emptyP, dataOutputP0, dataOutputP1, dataOutputP2, dataOutputP3,
        input  readyIn, idx, req,
        output popOutP0, popOutP1, popOutP2, popOutP3,
        output dataOut, portOut, validOut, counterOut, counterValid
    );

    modport slave (
        output init, emptyP, dataOutputP0, dataOutputP1, dataOutputP2, dataOutputP3,
        output readyIn, idx, req,
        input  popOutP0, popOutP1, popOutP2, popOutP3,
        input  dataOut, portOut, validOut, counterOut, counterValid
    );
endinterface

// File: rtl/egress_arbiter.sv
// Round-robin egress arbiter: pops four output FIFOs into a 2-entry tagged
// output buffer that feeds a valid/ready stream, and keeps a saturating
// delivered-word counter per port with a one-cycle readback.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-low reset
//   bus   : egress_if.master (FIFO pops/data, output stream, init, counter readback)
module egress_arbiter (
    input  logic     clk,
    input  logic     reset,
    egress_if.master bus
);
    typedef enum logic [1:0] {StReset, StInit, StIdle, StActive} state_e;

    state_e      state_q, state_d;
    logic [1:0]  ptr_q, ptr_d;
    logic        inflight_q, inflight_d;
    logic [1:0]  infl_port_q, infl_port_d;
    logic [13:0] buf_q [2];
    logic [13:0] buf_d [2];
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic [1:0]  occ_q, occ_d;
    logic [4:0]  cnt_q [4];
    logic [4:0]  cnt_d [4];
    logic [4:0]  cnt_out_q, cnt_out_d;
    logic        cnt_vld_q, cnt_vld_d;

    logic        xfer, credit_ok, found, pop_en, clear;
    logic [1:0]  gnt, cand, head_port;
    logic [3:0]  pop;
    logic [11:0] port_data [4];

    assign port_data[0] = bus.dataOutputP0;
    assign port_data[1] = bus.dataOutputP1;
    assign port_data[2] = bus.dataOutputP2;
    assign port_data[3] = bus.dataOutputP3;

    assign xfer      = (occ_q != 2'd0) && bus.readyIn;
    assign head_port = buf_q[rd_ptr_q][13:12];

    // First non-empty port at or after the pointer.
    always_comb begin
        found = 1'b0;
        gnt   = ptr_q;
        cand  = ptr_q;
        for (int k = 0; k < 4; k++) begin
            cand = ptr_q + 2'(k);
            if (!found && !bus.emptyP[cand]) begin
                found = 1'b1;
                gnt   = cand;
            end
        end
    end

    // Buffer slots already promised (held + in flight - leaving now) must stay below 2.
    assign credit_ok = ({1'b0, occ_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, xfer});
    assign pop_en    = (state_q == StActive) && !bus.init && credit_ok && found;
    assign pop       = pop_en ? (4'b0001 << gnt) : 4'b0000;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StReset:  state_d = StInit;
            StInit:   state_d = StIdle;
            StIdle:   if (bus.emptyP != 4'hF) state_d = StActive;
            StActive: if (bus.emptyP == 4'hF && !inflight_q && occ_q == 2'd0) state_d = StIdle;
            default:  state_d = StReset;
        endcase
        if (bus.init && (state_q == StIdle || state_q == StActive)) state_d = StInit;
    end

    // Clear on entry to INIT so nothing stale is visible during the INIT cycle.
    assign clear = (state_d == StInit) || (state_q == StInit);

    always_comb begin
        ptr_d       = pop_en ? gnt + 2'd1 : ptr_q;
        inflight_d  = pop_en;
        infl_port_d = pop_en ? gnt : infl_port_q;

        // FIFO data arrives the cycle after the pop; tag it with the remembered port.
        buf_d = buf_q;
        if (inflight_q) buf_d[wr_ptr_q] = {infl_port_q, port_data[infl_port_q]};
        wr_ptr_d = wr_ptr_q ^ inflight_q;
        rd_ptr_d = rd_ptr_q ^ xfer;
        occ_d    = occ_q + {1'b0, inflight_q} - {1'b0, xfer};

        cnt_d = cnt_q;
        if (xfer && cnt_q[head_port] != 5'd31) cnt_d[head_port] = cnt_q[head_port] + 5'd1;

        // Readback samples the counter before this cycle's increment.
        cnt_vld_d = bus.req && (state_q == StIdle || state_q == StActive);
        cnt_out_d = cnt_vld_d ? cnt_q[bus.idx] : cnt_out_q;

        if (clear) begin
            ptr_d       = 2'd0;
            inflight_d  = 1'b0;
            infl_port_d = 2'd0;
            buf_d       = '{default: '0};
            wr_ptr_d    = 1'b0;
            rd_ptr_d    = 1'b0;
            occ_d       = 2'd0;
            cnt_d       = '{default: '0};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StReset;
            ptr_q       <= 2'd0;
            inflight_q  <= 1'b0;
            infl_port_q <= 2'd0;
            buf_q       <= '{default: '0};
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
            occ_q       <= 2'd0;
            cnt_q       <= '{default: '0};
            cnt_out_q   <= 5'd0;
            cnt_vld_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            inflight_q  <= inflight_d;
            infl_port_q <= infl_port_d;
            buf_q       <= buf_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            occ_q       <= occ_d;
            cnt_q       <= cnt_d;
            cnt_out_q   <= cnt_out_d;
            cnt_vld_q   <= cnt_vld_d;
        end
    end

    assign bus.popOutP0     = pop[0];
    assign bus.popOutP1     = pop[1];
    assign bus.popOutP2     = pop[2];
    assign bus.popOutP3     = pop[3];
    assign bus.dataOut      = buf_q[rd_ptr_q][11:0];
    assign bus.portOut      = head_port;
    assign bus.validOut     = (occ_q != 2'd0);
    assign bus.counterOut   = cnt_out_q;
    assign bus.counterValid = cnt_vld_q;
endmodule
